// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the two-master memory bus arbiter.
package mem_bus_arbiter_pkg;

  // Width of the ACCESS-phase wait counter (covers 0..7 wait states).
  localparam int WAIT_W   = 3;
  localparam int WAIT_MAX = (1 << WAIT_W) - 1;

  // Arbiter FSM state encoding.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Two-way select of a 16-bit field by master index.
  function automatic logic [15:0] sel16(input logic sel, input logic [15:0] a0,
                                        input logic [15:0] a1);
    return sel ? a1 : a0;
  endfunction

  // Two-way select of an 8-bit field by master index.
  function automatic logic [7:0] sel8(input logic sel, input logic [7:0] d0,
                                      input logic [7:0] d1);
    return sel ? d1 : d0;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_grant2.sv
// Two-way round-robin grant decision: on a tie the master not granted last wins.
module mem_bus_arbiter_rr_grant2 (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last_grant,
  output logic o_any,
  output logic o_grant
);

  // Pure combinational choice; the caller registers the result.
  always_comb begin
    o_any   = i_req0 | i_req1;
    o_grant = (i_req0 & i_req1) ? ~i_last_grant : i_req1;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates two masters onto one single-ported memory with a fixed number of
// wait states. Each access runs IDLE -> ACCESS (WAIT_STATES+1 cycles) -> DONE.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [15:0] m0_addr,
  input  logic [7:0]  m0_wdata,
  output logic [7:0]  m0_rdata,
  output logic        m0_ack,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [15:0] m1_addr,
  input  logic [7:0]  m1_wdata,
  output logic [7:0]  m1_rdata,
  output logic        m1_ack,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        busy,
  output logic        grant
);

  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_STATES);

  state_e            r_state;
  logic [WAIT_W-1:0] r_cnt;
  logic              r_last_grant;
  logic              r_grant;
  logic              r_we;
  logic [15:0]       r_mem_addr;
  logic [7:0]        r_mem_wdata;
  logic              r_mem_rd;
  logic              r_mem_wr;
  logic [7:0]        r_m0_rdata;
  logic [7:0]        r_m1_rdata;
  logic              r_m0_ack;
  logic              r_m1_ack;
  logic              r_busy;

  logic              w_any;
  logic              w_gnt;
  logic              w_sel_we;

  mem_bus_arbiter_rr_grant2 u_rr (
    .i_req0      (m0_req),
    .i_req1      (m1_req),
    .i_last_grant(r_last_grant),
    .o_any       (w_any),
    .o_grant     (w_gnt)
  );

  assign w_sel_we = w_gnt ? m1_we : m0_we;

  // Arbiter FSM: grant in IDLE, drive memory in ACCESS, pulse the owner's ack in DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_we         <= 1'b0;
      r_mem_addr   <= 16'h0000;
      r_mem_wdata  <= 8'h00;
      r_mem_rd     <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_m0_rdata   <= 8'h00;
      r_m1_rdata   <= 8'h00;
      r_m0_ack     <= 1'b0;
      r_m1_ack     <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_m0_ack <= 1'b0;
          r_m1_ack <= 1'b0;
          if (w_any) begin
            r_grant      <= w_gnt;
            r_last_grant <= w_gnt;
            r_we         <= w_sel_we;
            r_mem_addr   <= sel16(w_gnt, m0_addr, m1_addr);
            r_mem_wdata  <= sel8(w_gnt, m0_wdata, m1_wdata);
            r_mem_rd     <= ~w_sel_we;
            r_mem_wr     <= w_sel_we;
            r_cnt        <= WAIT_LOAD;
            r_busy       <= 1'b1;
            r_state      <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (r_cnt == '0) begin
            // Read data is valid on the last ACCESS cycle only.
            if (!r_we) begin
              if (r_grant) r_m1_rdata <= mem_rdata;
              else         r_m0_rdata <= mem_rdata;
            end
            r_m0_ack <= ~r_grant;
            r_m1_ack <= r_grant;
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            r_state  <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_DONE: begin
          // No arbitration here; a request seen now is evaluated in IDLE.
          r_m0_ack <= 1'b0;
          r_m1_ack <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= ST_IDLE;
        end
        default: begin
          r_mem_rd <= 1'b0;
          r_mem_wr <= 1'b0;
          r_m0_ack <= 1'b0;
          r_m1_ack <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign m0_rdata  = r_m0_rdata;
  assign m1_rdata  = r_m1_rdata;
  assign m0_ack    = r_m0_ack;
  assign m1_ack    = r_m1_ack;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_rd    = r_mem_rd;
  assign mem_wr    = r_mem_wr;
  assign busy      = r_busy;
  assign grant     = r_grant;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: drivers push expected transactions,
// a negedge monitor checks memory strobes and acks against them.
module tb_mem_bus_arbiter;

  localparam int WS = 1;

  logic        clk;
  logic        reset_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [15:0] m0_addr, m1_addr;
  logic [7:0]  m0_wdata, m1_wdata;
  logic [7:0]  m0_rdata, m1_rdata;
  logic        m0_ack, m1_ack;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_rd, mem_wr, busy, grant;

  // WAIT_STATES=0 and WAIT_STATES=7 instances (only master 0 used)
  logic        z_req, s_req;
  logic [15:0] z_addr, s_addr;
  logic [7:0]  z_rdata, s_rdata, z_m1_rdata, s_m1_rdata;
  logic        z_ack, s_ack, z_m1_ack, s_m1_ack;
  logic [15:0] z_mem_addr, s_mem_addr;
  logic [7:0]  z_mem_wdata, s_mem_wdata;
  logic        z_mem_rd, z_mem_wr, z_busy, z_grant;
  logic        s_mem_rd, s_mem_wr, s_busy, s_grant;
  logic        lo;
  logic [15:0] lo16;
  logic [7:0]  lo8;

  function automatic logic [7:0] rd_fn(input logic [15:0] a);
    return (a == 16'h1234) ? 8'hA5 : (a[7:0] ^ a[15:8] ^ 8'h3C);
  endfunction

  assign mem_rdata = rd_fn(mem_addr);

  mem_bus_arbiter #(.WAIT_STATES(WS)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .busy(busy), .grant(grant)
  );

  mem_bus_arbiter #(.WAIT_STATES(0)) dut_z (
    .clk(clk), .reset_n(reset_n),
    .m0_req(z_req), .m0_we(lo), .m0_addr(z_addr), .m0_wdata(lo8),
    .m0_rdata(z_rdata), .m0_ack(z_ack),
    .m1_req(lo), .m1_we(lo), .m1_addr(lo16), .m1_wdata(lo8),
    .m1_rdata(z_m1_rdata), .m1_ack(z_m1_ack),
    .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata), .mem_rdata(rd_fn(z_mem_addr)),
    .mem_rd(z_mem_rd), .mem_wr(z_mem_wr), .busy(z_busy), .grant(z_grant)
  );

  mem_bus_arbiter #(.WAIT_STATES(7)) dut_s (
    .clk(clk), .reset_n(reset_n),
    .m0_req(s_req), .m0_we(lo), .m0_addr(s_addr), .m0_wdata(lo8),
    .m0_rdata(s_rdata), .m0_ack(s_ack),
    .m1_req(lo), .m1_we(lo), .m1_addr(lo16), .m1_wdata(lo8),
    .m1_rdata(s_m1_rdata), .m1_ack(s_m1_ack),
    .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .mem_rdata(rd_fn(s_mem_addr)),
    .mem_rd(s_mem_rd), .mem_wr(s_mem_wr), .busy(s_busy), .grant(s_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          m;
    bit          we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    int          ack_cyc;  // -1: not checked
    int          period;   // 0: not checked
  } txn_t;

  txn_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_exp(input int m, input bit we, input logic [15:0] a,
                          input logic [7:0] wd, input logic [7:0] rd,
                          input int ack_cyc, input int period);
    txn_t t;
    t.m = m; t.we = we; t.addr = a; t.wdata = wd; t.rdata = rd;
    t.ack_cyc = ack_cyc; t.period = period;
    q.push_back(t);
  endtask

  task automatic issue(input int m, input bit we, input logic [15:0] a,
                       input logic [7:0] wd, input logic [7:0] rd, input bit latchk);
    if (m == 0) begin m0_we = we; m0_addr = a; m0_wdata = wd; m0_req = 1'b1; end
    else        begin m1_we = we; m1_addr = a; m1_wdata = wd; m1_req = 1'b1; end
    push_exp(m, we, a, wd, rd, latchk ? cyc + WS + 2 : -1, 0);
  endtask

  task automatic wait_ack(input int m);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if ((m == 0) ? m0_ack : m1_ack) return;
    end
    chk("ack_timeout", (m == 0) ? m0_ack : m1_ack, 1);
  endtask

  task automatic wait_strobe();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_rd | mem_wr) return;
    end
    chk("strobe_timeout", {31'd0, mem_rd | mem_wr}, 1);
  endtask

  task automatic check_reset_outputs();
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_mem_wdata", mem_wdata, 8'h00);
    chk("rst_rdata", {m1_rdata, m0_rdata}, 16'h0000);
    chk("rst_strobes", {mem_rd, mem_wr}, 2'b00);
    chk("rst_acks", {m1_ack, m0_ack}, 2'b00);
    chk("rst_busy_grant", {busy, grant}, 2'b00);
  endtask

  // Monitor: per-cycle strobe checks and per-ack scoreboard pops
  int          strobe_cnt = 0;
  int          last_ack[2] = '{0, 0};
  logic [7:0]  sh0 = 8'h00, sh1 = 8'h00;
  always @(negedge clk) begin
    if (!reset_n) begin
      strobe_cnt = 0;
      sh0 = 8'h00;
      sh1 = 8'h00;
    end else begin
      if (mem_rd | mem_wr) begin
        strobe_cnt++;
        chk("strobe_excl", {31'd0, mem_rd & mem_wr}, 0);
        if (q.size() == 0) chk("unexpected_strobe", {30'd0, mem_rd, mem_wr}, 0);
        else begin
          chk("mem_addr", mem_addr, q[0].addr);
          chk("mem_wr_dir", {31'd0, mem_wr}, {31'd0, q[0].we});
          if (q[0].we) chk("mem_wdata", mem_wdata, q[0].wdata);
        end
      end
      if (m0_ack | m1_ack) begin
        if (q.size() == 0) chk("unexpected_ack", {30'd0, m1_ack, m0_ack}, 0);
        else begin
          txn_t t;
          t = q.pop_front();
          chk("ack_both", {31'd0, m0_ack & m1_ack}, 0);
          chk("ack_master", m1_ack ? 1 : 0, t.m);
          chk("grant_owner", {31'd0, grant}, t.m);
          chk("busy_done", {31'd0, busy}, 1);
          chk("access_len", strobe_cnt, WS + 1);
          if (t.ack_cyc >= 0) chk("ack_latency", cyc, t.ack_cyc);
          if (t.period > 0)   chk("ack_period", cyc - last_ack[t.m], t.period);
          last_ack[t.m] = cyc;
          if (!t.we) begin
            if (t.m == 0) sh0 = t.rdata;
            else          sh1 = t.rdata;
          end
          chk("m0_rdata", m0_rdata, sh0);
          chk("m1_rdata", m1_rdata, sh1);
        end
        strobe_cnt = 0;
      end
    end
  end

  initial begin
    int acks;
    int t0;
    int n;
    reset_n = 1'b0;
    {m0_req, m0_we, m1_req, m1_we} = '0;
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
    z_req = 1'b0; s_req = 1'b0; z_addr = '0; s_addr = '0;
    lo = 1'b0; lo16 = '0; lo8 = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    reset_n = 1'b1;

    // Single accesses with latency checks
    @(negedge clk); issue(0, 1'b0, 16'h1234, 8'h00, 8'hA5, 1'b1);
    wait_ack(0); m0_req = 1'b0;
    @(negedge clk); issue(1, 1'b1, 16'h8000, 8'h3C, 8'h00, 1'b1);
    wait_ack(1); m1_req = 1'b0;
    @(negedge clk); issue(1, 1'b0, 16'h4455, 8'h00, 8'h2D, 1'b1);
    wait_ack(1); m1_req = 1'b0;
    @(negedge clk); issue(0, 1'b1, 16'h00FF, 8'h77, 8'h00, 1'b1);
    wait_ack(0); m0_req = 1'b0;

    // m1 arrives during m0 ACCESS, m0 re-requests in DONE: m1 must win next
    @(negedge clk); issue(0, 1'b0, 16'h2001, 8'h00, 8'h1D, 1'b1);
    wait_strobe();
    issue(1, 1'b0, 16'h00F0, 8'h00, 8'hCC, 1'b0);
    wait_ack(0);
    issue(0, 1'b0, 16'h4455, 8'h00, 8'h2D, 1'b0);
    wait_ack(1); m1_req = 1'b0;
    wait_ack(0); m0_req = 1'b0;

    // Reset during an m0 write ACCESS, then the held request is served again
    @(negedge clk); issue(0, 1'b1, 16'h0AAA, 8'h5A, 8'h00, 1'b0);
    wait_strobe();
    #2 reset_n = 1'b0;
    #1;
    chk("abort_mem_wr", {31'd0, mem_wr}, 0);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_m0_ack", {31'd0, m0_ack}, 0);
    q.delete();
    @(negedge clk);
    @(negedge clk);
    push_exp(0, 1'b1, 16'h0AAA, 8'h5A, 8'h00, cyc + WS + 2, 0);
    reset_n = 1'b1;
    wait_ack(0); m0_req = 1'b0;

    // Fresh reset, then both masters request continuously
    @(negedge clk); reset_n = 1'b0;
    #1 check_reset_outputs();
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    m0_we = 1'b0; m0_addr = 16'h00F0; m0_wdata = 8'h00;
    m1_we = 1'b1; m1_addr = 16'h1111; m1_wdata = 8'h99;
    m0_req = 1'b1; m1_req = 1'b1;
    push_exp(0, 1'b0, 16'h00F0, 8'h00, 8'hCC, cyc + WS + 2, 0);
    push_exp(1, 1'b1, 16'h1111, 8'h99, 8'h00, cyc + WS + 2 + (WS + 3), 0);
    push_exp(0, 1'b0, 16'h00F0, 8'h00, 8'hCC, -1, 2 * (WS + 3));
    push_exp(1, 1'b1, 16'h1111, 8'h99, 8'h00, -1, 2 * (WS + 3));
    acks = 0;
    for (int i = 0; i < 100 && acks < 4; i++) begin
      @(negedge clk);
      if (m0_ack | m1_ack) acks++;
    end
    chk("rr_ack_count", acks, 4);
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);

    // WAIT_STATES = 0: one ACCESS cycle, ack two edges after the request edge
    @(negedge clk); z_addr = 16'h00F0; z_req = 1'b1; t0 = cyc; n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (z_mem_rd) n++;
      if (z_ack) break;
    end
    chk("ws0_ack_cyc", cyc, t0 + 2);
    chk("ws0_access_len", n, 1);
    chk("ws0_rdata", z_rdata, 8'hCC);
    z_req = 1'b0;

    // WAIT_STATES = 7: eight ACCESS cycles
    @(negedge clk); s_addr = 16'h4455; s_req = 1'b1; t0 = cyc; n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (s_mem_rd) n++;
      if (s_ack) break;
    end
    chk("ws7_ack_cyc", cyc, t0 + 9);
    chk("ws7_access_len", n, 8);
    chk("ws7_rdata", s_rdata, 8'h2D);
    s_req = 1'b0;

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter WAIT_STATES, default 1, extra memory cycles per access (range 0..7).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 m0_req / m0_we  input  1 / 1  master 0 (CPU) access request, write-enable.
REQ-005 m0_addr / m0_wdata  input  16 / 8  master 0 address, write data.
REQ-006 m0_rdata / m0_ack  output  8 / 1  master 0 read data, one-cycle completion pulse.
REQ-007 m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ack  same directions/widths  master 1 (DMA/loader).
REQ-008 mem_addr / mem_wdata  output  16 / 8  shared memory port address, write data.
REQ-009 mem_rdata  input  8  memory read data, valid on final ACCESS cycle.
REQ-010 mem_rd / mem_wr  output  1 / 1  memory read/write strobes, mutually exclusive.
REQ-011 busy / grant  output  1 / 1  transaction in flight; index of current owner (0 or 1).

Function
REQ-012 FSM states IDLE, ACCESS, DONE; encoding shared via package.
REQ-013 IDLE: no request -> stay IDLE, all strobes and acks low.
REQ-014 IDLE, exactly one req high -> grant that master, latch its addr/we/wdata, go ACCESS next edge.
REQ-015 IDLE, both req high -> grant master not granted last (round-robin); last_grant updates on each grant.
REQ-016 ACCESS lasts exactly WAIT_STATES+1 cycles, counted by 3-bit wait counter loaded with WAIT_STATES on entry.
REQ-017 During ACCESS: mem_addr/mem_wdata driven from latched values; mem_rd = ~we, mem_wr = we, held stable all ACCESS cycles.
REQ-018 Final ACCESS cycle (counter = 0): latch mem_rdata into owner's rdata register on reads; go DONE.
REQ-019 DONE: assert owner's ack exactly one cycle, strobes low, then IDLE; no new grant evaluated in DONE.
REQ-020 Latency: req sampled high at edge N -> ack high in cycle N+WAIT_STATES+2; back-to-back throughput one access per WAIT_STATES+3 cycles.
REQ-021 mX_rdata holds last read value until next read by that master; writes leave it unchanged.
REQ-022 Masters hold req and request fields until ack; req dropped mid-ACCESS -> access still completes and ack still pulses.
REQ-023 Non-owner req held during a transaction is served first at next IDLE regardless of round-robin tie.
REQ-024 busy high in ACCESS and DONE; grant holds last owner when IDLE.
REQ-025 Outputs registered; no combinational path req -> mem strobes.

Reset
REQ-026 reset_n low asynchronously forces IDLE, counter 0, last_grant 1 (master 0 wins first tie), grant 0.
REQ-027 Reset values: mem_addr 16'h0000, mem_wdata/m0_rdata/m1_rdata 8'h00, mem_rd/mem_wr/acks/busy 0.
REQ-028 Reset mid-ACCESS drops strobes immediately; aborted access produces no ack; first edge after release evaluates IDLE.

Structure
REQ-029 State encoding and WAIT_STATES width constant live in shared header alongside instructions.vh definitions.
REQ-030 Single module; round-robin grant logic optionally in sub-module rr_grant2 (2-way, last_grant input).

Verification
REQ-031 WAIT_STATES=1, m0 read 16'h1234, memory returns 8'hA5 -> mem_rd 2 cycles, m0_ack cycle N+3, m0_rdata 8'hA5, m1_ack never.
REQ-032 m1 write 8'h3C to 16'h8000 -> mem_wr high 2 cycles with addr 16'h8000/data 8'h3C, mem_rd low throughout, m1_ack once.
REQ-033 Both req continuously after reset -> grants 0,1,0,1; each master acked every 2*(WAIT_STATES+3) cycles.
REQ-034 WAIT_STATES=0 -> single ACCESS cycle, ack at N+2; WAIT_STATES=7 -> eight ACCESS cycles, ack at N+9.
REQ-035 reset_n low during ACCESS of m0 write -> mem_wr falls without clock edge, no m0_ack, post-reset m0 req re-served fully.
REQ-036 m1_req asserted during m0 ACCESS, m0 re-requests in DONE -> next grant is m1.
